// File: rtl/pulse_sched_if.sv
// Handshake bundle for the shared pulse scheduler.
// master: requester side; slave: scheduler side.
//
// Ports (slave view):
//   REQ   in  N_REQ        per-requester level request
//   DELAY in  N_REQ*CNT_W  packed start delays, field i at [i*CNT_W +: CNT_W]
//   WIDTH in  N_REQ*CNT_W  packed pulse widths, same packing
//   ABORT in  1            synchronous abort of the pulse in progress
//   GNT   out N_REQ        one-hot grant
//   DONE  out N_REQ        one-cycle completion strobe
//   PULSE out 1            shared pulse output
//   BUSY  out 1            scheduler not idle
interface pulse_sched_if #(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) ();
    logic [N_REQ-1:0]       REQ;
    logic [N_REQ*CNT_W-1:0] DELAY;
    logic [N_REQ*CNT_W-1:0] WIDTH;
    logic                   ABORT;
    logic [N_REQ-1:0]       GNT;
    logic [N_REQ-1:0]       DONE;
    logic                   PULSE;
    logic                   BUSY;

    modport master (
        output REQ, DELAY, WIDTH, ABORT,
        input  GNT, DONE, PULSE, BUSY
    );

    modport slave (
        input  REQ, DELAY, WIDTH, ABORT,
        output GNT, DONE, PULSE, BUSY
    );
endinterface

// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one pulse generator between N_REQ requesters.
// Latches the winner's delay/width, times both phases, then strobes DONE.
//
// Ports:
//   CLK    in  fabric clock, rising edge
//   RESETN in  asynchronous active-low reset
//   bus    pulse_sched_if.slave (REQ/DELAY/WIDTH/ABORT in, GNT/DONE/PULSE/BUSY out)
module pulse_sched #(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input  logic          CLK,
    input  logic          RESETN,
    pulse_sched_if.slave  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DLY,
        HIGH,
        FIN
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     wid_q;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        win_q;
    logic [N_REQ-1:0]     gnt_q;
    logic [N_REQ-1:0]     done_q;
    logic                 pulse_q;
    logic                 busy_q;

    logic [PW-1:0]        win;
    logic                 any_req;
    logic [CNT_W-1:0]     dly_sel;
    logic [CNT_W-1:0]     wid_sel;
    logic [CNT_W-1:0]     wid_eff;
    logic [PW-1:0]        nxt_ptr;

    // First requester at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        int j;
        j       = 0;
        win     = '0;
        any_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any_req && bus.REQ[j]) begin
                any_req = 1'b1;
                win     = PW'(j);
            end
        end
    end

    assign dly_sel = bus.DELAY[int'(win)*CNT_W +: CNT_W];
    assign wid_sel = bus.WIDTH[int'(win)*CNT_W +: CNT_W];
    // A zero width still produces a one-cycle pulse.
    assign wid_eff = (wid_sel == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : wid_sel;
    // Served requester drops to lowest priority.
    assign nxt_ptr = (win_q == PW'(N_REQ-1)) ? '0 : win_q + 1'b1;

    // Counters are loaded with (length-1) so all-ones lengths never wrap.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE;
            cnt     <= '0;
            wid_q   <= '0;
            ptr     <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q  <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                        win_q  <= win;
                        wid_q  <= wid_eff;
                        busy_q <= 1'b1;
                        if (dly_sel == '0) begin
                            state   <= HIGH;
                            pulse_q <= 1'b1;
                            cnt     <= wid_eff - 1'b1;
                        end else begin
                            state <= DLY;
                            cnt   <= dly_sel - 1'b1;
                        end
                    end
                end
                DLY: begin
                    if (bus.ABORT) begin
                        state   <= IDLE;
                        gnt_q   <= '0;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt     <= '0;
                        ptr     <= nxt_ptr;
                    end else if (cnt == '0) begin
                        state   <= HIGH;
                        pulse_q <= 1'b1;
                        cnt     <= wid_q - 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (bus.ABORT) begin
                        state   <= IDLE;
                        gnt_q   <= '0;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt     <= '0;
                        ptr     <= nxt_ptr;
                    end else if (cnt == '0) begin
                        state   <= FIN;
                        pulse_q <= 1'b0;
                        gnt_q   <= '0;
                        done_q  <= gnt_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    ptr    <= nxt_ptr;
                end
            endcase
        end
    end

    assign bus.GNT   = gnt_q;
    assign bus.DONE  = done_q;
    assign bus.PULSE = pulse_q;
    assign bus.BUSY  = busy_q;
endmodule
